// File: rtl/lcd_text_feeder.sv
// Frame-buffer front end for the LCD controller: holds two 16-char lines and
// streams them as address commands plus packed 4-char words on refresh.
module lcd_text_feeder #(
  parameter int ACK_TIMEOUT  = 4,
  parameter bit AUTO_REFRESH = 1'b0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        wr_en,
  input  logic [4:0]  wr_addr,
  input  logic [7:0]  wr_char,
  input  logic        refresh_req,
  output logic        busy,
  output logic        done,
  input  logic        LCD_Available,
  output logic [31:0] data,
  output logic        selectCD,
  output logic        enableWriting
);

  localparam int CW = $clog2(ACK_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, LOAD, ISSUE, WAIT_ACK, WAIT_DONE, NEXT} state_t;

  state_t          state_q, state_d;
  logic [7:0]      buf_q [32];
  logic [7:0]      buf_d [32];
  logic [3:0]      step_q, step_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [31:0]     data_q, data_d;
  logic            sel_q, sel_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            pending_q, pending_d;

  logic [3:0]      nstep;
  logic [2:0]      k;
  logic [4:0]      base;
  logic [31:0]     word;
  logic            word_cmd;
  logic            load;

  always_comb begin
    buf_d = buf_q;
    if (wr_en) buf_d[wr_addr] = wr_char;

    // Word for the step about to be loaded; read through buf_d so a write on
    // the loading edge is already visible.
    nstep    = (state_q == IDLE) ? 4'd0 : step_q + 4'd1;
    k        = (nstep < 4'd5) ? 3'(nstep - 4'd1) : 3'(nstep - 4'd2);
    base     = {k[1:0] == 2'b00 && 1'b0 ? 3'd0 : k, 2'b00};
    word_cmd = 1'b0;
    word     = {buf_d[base], buf_d[base + 5'd1], buf_d[base + 5'd2], buf_d[base + 5'd3]};
    if (nstep == 4'd0) begin
      word_cmd = 1'b1;
      word     = 32'h0000_0080;
    end else if (nstep == 4'd5) begin
      word_cmd = 1'b1;
      word     = 32'h0000_00C0;
    end

    state_d   = state_q;
    step_d    = step_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    sel_d     = sel_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    pending_d = pending_q;
    load      = 1'b0;

    case (state_q)
      IDLE: if (pending_q) begin
        state_d   = LOAD;
        step_d    = 4'd0;
        busy_d    = 1'b1;
        pending_d = 1'b0;
        load      = 1'b1;
      end
      LOAD: if (LCD_Available) state_d = ISSUE;
      ISSUE: begin
        cnt_d   = '0;
        state_d = WAIT_ACK;
      end
      WAIT_ACK: begin
        if (!LCD_Available) begin
          state_d = WAIT_DONE;
        end else begin
          // Controller never dropped its ready flag: assume it took the write.
          cnt_d = cnt_q + 1'b1;
          if (cnt_d == CW'(ACK_TIMEOUT)) state_d = WAIT_DONE;
        end
      end
      WAIT_DONE: if (LCD_Available) state_d = NEXT;
      NEXT: begin
        if (step_q == 4'd9) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end else begin
          step_d  = step_q + 4'd1;
          state_d = LOAD;
          load    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (load) begin
      data_d = word;
      sel_d  = !word_cmd;
    end

    // A new request wins over the launch clear so it buys one more refresh.
    if (refresh_req || (AUTO_REFRESH && wr_en)) pending_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q   <= IDLE;
      for (int i = 0; i < 32; i++) buf_q[i] <= 8'h20;
      step_q    <= '0;
      cnt_q     <= '0;
      data_q    <= '0;
      sel_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      pending_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      buf_q     <= buf_d;
      step_q    <= step_d;
      cnt_q     <= cnt_d;
      data_q    <= data_d;
      sel_q     <= sel_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      pending_q <= pending_d;
    end
  end

  assign data          = data_q;
  assign selectCD      = sel_q;
  assign enableWriting = (state_q == ISSUE);
  assign busy          = busy_q;
  assign done          = done_q;

endmodule
